nco_lut_sequencer: RTL and testbench

NCO_LUT_SEQUENCER -- requirements
Module: nco_lut_sequencer

---
 rtl/nco_lut_sequencer.sv | 127 ++++++++++++
 tb/tb_nco_lut_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_lut_sequencer.sv
// NCO driving a dual-port sine/cosine lookup SRAM: loads the table through port 0,
// then streams phase-indexed reads through port 1 with a three-edge read latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accept table words on ld_*, write them to SRAM port 0, no reads
// RUN   | table complete; each en cycle issues one port-1 read
module nco_lut_sequencer #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      reload,
    input  logic                      fcw_we,
    input  logic [PHASE_W-1:0]        fcw,
    input  logic [PHASE_W-1:0]        phase_off,
    input  logic                      en,
    output logic                      csb0,
    output logic                      web0,
    output logic [3:0]                wmask0,
    output logic [ADDR_W-1:0]         addr0,
    output logic [DATA_W-1:0]         din0,
    output logic                      csb1,
    output logic [ADDR_W-1:0]         addr1,
    input  logic [DATA_W-1:0]         dout1,
    output logic signed [15:0]        sin_out,
    output logic signed [15:0]        cos_out,
    output logic                      out_valid,
    output logic                      table_ready
);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    load_cnt;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   fcw_q;
    logic                 req_v;
    logic                 sram_v;
    logic [PHASE_W-1:0]   phase_sum;

    assign phase_sum = phase + phase_off;
    assign ld_ready  = (state == LOAD) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_cnt    <= '0;
            phase       <= '0;
            fcw_q       <= '0;
            csb0        <= 1'b1;
            web0        <= 1'b1;
            wmask0      <= 4'h0;
            addr0       <= '0;
            din0        <= '0;
            csb1        <= 1'b1;
            addr1       <= '0;
            sin_out     <= '0;
            cos_out     <= '0;
            out_valid   <= 1'b0;
            table_ready <= 1'b0;
            req_v       <= 1'b0;
            sram_v      <= 1'b0;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= 4'h0;
            if (fcw_we)
                fcw_q <= fcw;

            case (state)
                LOAD: begin
                    csb1      <= 1'b1;
                    req_v     <= 1'b0;
                    sram_v    <= 1'b0;
                    out_valid <= 1'b0;
                    if (reload) begin
                        load_cnt <= '0;
                    end else if (ld_valid) begin
                        csb0     <= 1'b0;
                        web0     <= 1'b0;
                        wmask0   <= 4'hF;
                        addr0    <= load_cnt;
                        din0     <= ld_data;
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == '1) begin
                            state       <= RUN;
                            table_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        // Reads already issued are dropped; phase and fcw survive.
                        state       <= LOAD;
                        load_cnt    <= '0;
                        table_ready <= 1'b0;
                        req_v       <= 1'b0;
                        sram_v      <= 1'b0;
                        out_valid   <= 1'b0;
                        csb1        <= 1'b1;
                    end else begin
                        csb1      <= !en;
                        req_v     <= en;
                        sram_v    <= req_v;
                        out_valid <= sram_v;
                        if (sram_v) begin
                            sin_out <= $signed(dout1[15:0]);
                            cos_out <= $signed(dout1[31:16]);
                        end
                        if (en) begin
                            phase <= phase + fcw_q;
                            addr1 <= phase_sum[PHASE_W-1 -: ADDR_W];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_lut_sequencer.sv
// Bench for nco_lut_sequencer: behavioural SRAM, NCO reference model and a read
// scoreboard popped whenever out_valid is expected.
module tb_nco_lut_sequencer;

    logic               clk = 1'b0;
    logic               rst, ld_valid, ld_ready, reload, fcw_we, en;
    logic [31:0]        ld_data, fcw, phase_off;
    logic               csb0, web0, csb1;
    logic [3:0]         wmask0;
    logic [7:0]         addr0, addr1;
    logic [31:0]        din0, dout1;
    logic signed [15:0] sin_out, cos_out;
    logic               out_valid, table_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [88:0] RST_VEC = {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00,
                                       16'h0, 16'h0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    nco_lut_sequencer #(.PHASE_W(32), .ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .reload(reload), .fcw_we(fcw_we), .fcw(fcw), .phase_off(phase_off), .en(en),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1),
        .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid), .table_ready(table_ready)
    );

    // Synchronous dual-port SRAM: inputs sampled on the edge, read data one edge later.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!csb0 && !web0)
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
        if (!csb1)
            dout1 <= mem[addr1];
    end

    logic [31:0] tbl [256];
    logic [31:0] m_phase, m_fcw, last_out;
    logic        m_run, p_r, p_s, exp_ov;
    logic [7:0]  exp_addr;
    logic [31:0] rd_q [$];
    logic [39:0] wr_q [$];

    task automatic model_clear();
        m_phase = 0; m_fcw = 0; last_out = 0; m_run = 0;
        p_r = 0; p_s = 0; exp_ov = 0;
        rd_q.delete(); wr_q.delete();
    endtask

    // One NCO cycle: drive, advance the model, then compare what the DUT shows after the edge.
    task automatic step_nco(input logic e, input logic we, input logic [31:0] f, input logic rl);
        logic        req, was_run;
        logic [31:0] ps, exp_d;
        logic [7:0]  a_n;
        a_n = 8'h00;
        was_run = m_run;
        en = e; fcw_we = we; fcw = f; reload = rl;
        ld_valid = m_run ? 1'($urandom_range(0, 1)) : 1'b0;
        ld_data = $urandom;
        req = m_run && e && !rl;
        if (req) begin
            ps = m_phase + phase_off;
            a_n = ps[31:24];
            rd_q.push_back(tbl[a_n]);
            m_phase = m_phase + m_fcw;
        end
        if (we) m_fcw = f;
        if (was_run) begin
            checks++;
            if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_run: got %b expected 0", ld_ready); end
        end
        @(posedge clk); #1;
        reload = 1'b0; fcw_we = 1'b0; ld_valid = 1'b0;
        if (rl && m_run) begin
            m_run = 0; p_r = 0; p_s = 0; exp_ov = 0;
            rd_q.delete();
        end else begin
            exp_ov = p_s; p_s = p_r; p_r = req;
        end
        if (req) exp_addr = a_n;
        if (was_run) begin
            checks++;
            if (csb0 !== 1'b1) begin errors++; $display("FAIL no_write_in_run: csb0 got %b expected 1", csb0); end
        end
        checks++;
        if (out_valid !== exp_ov) begin errors++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov); end
        checks++;
        if (csb1 !== !p_r) begin errors++; $display("FAIL csb1: got %b expected %b", csb1, !p_r); end
        if (p_r) begin
            checks++;
            if (addr1 !== exp_addr) begin errors++; $display("FAIL addr1: got %0d expected %0d", addr1, exp_addr); end
        end
        if (exp_ov) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++; $display("FAIL read_queue: got empty expected an outstanding read");
            end else begin
                exp_d = rd_q.pop_front();
                if ({cos_out, sin_out} !== exp_d) begin
                    errors++; $display("FAIL read_data: got %h expected %h", {cos_out, sin_out}, exp_d);
                end
                last_out = exp_d;
            end
        end else begin
            checks++;
            if ({cos_out, sin_out} !== last_out) begin
                errors++; $display("FAIL output_hold: got %h expected %h", {cos_out, sin_out}, last_out);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; ld_valid = 1; reload = 0; fcw_we = 0; en = 0;
        fcw = 0; phase_off = 0; ld_data = 0;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_in_rst: got %b expected 0", ld_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({csb0, web0, wmask0, addr0, din0, csb1, addr1, sin_out, cos_out, out_valid, table_ready} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h",
                {csb0, web0, wmask0, addr0, din0, csb1, addr1, sin_out, cos_out, out_valid, table_ready}, RST_VEC);
        end
        rst = 0; ld_valid = 0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_after_rst: got %b expected 1", ld_ready); end
        model_clear();
    endtask

    task automatic test_load();
        int          hs_n, writes;
        logic        last, done;
        logic [39:0] exp_w;
        hs_n = 0; writes = 0; done = 0;
        en = 0; reload = 0; fcw_we = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            ld_valid = (hs_n < 256) ? 1'($urandom_range(0, 1)) : 1'b0;
            ld_data = tbl[hs_n[7:0]];
            #1;
            last = 0;
            if (ld_valid && ld_ready) begin
                wr_q.push_back({hs_n[7:0], tbl[hs_n[7:0]]});
                last = (hs_n == 255);
                hs_n++;
            end
            @(posedge clk); #1;
            checks++;
            if (!csb0) begin
                writes++;
                if (wr_q.size() == 0) begin
                    errors++; $display("FAIL load_write: got unexpected write addr %0d", addr0);
                end else begin
                    exp_w = wr_q.pop_front();
                    if ({addr0, din0, web0, wmask0} !== {exp_w, 1'b0, 4'hF}) begin
                        errors++;
                        $display("FAIL load_write: got %h expected %h", {addr0, din0, web0, wmask0}, {exp_w, 1'b0, 4'hF});
                    end
                end
            end else if (web0 !== 1'b1 || wmask0 !== 4'h0) begin
                errors++; $display("FAIL idle_port0: got web0=%b wmask0=%h expected 1/0", web0, wmask0);
            end
            checks++;
            if (table_ready !== last) begin errors++; $display("FAIL table_ready: got %b expected %b", table_ready, last); end
            if (last) begin
                checks++;
                if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_after_load: got %b expected 0", ld_ready); end
                done = 1;
            end
        end
        ld_valid = 0;
        checks++;
        if (!done || writes != 256 || wr_q.size() != 0) begin
            errors++; $display("FAIL load_count: got %0d writes done=%b expected 256 done=1", writes, done);
        end
        m_run = 1;
    endtask

    task automatic test_stream();
        int first_ov;
        first_ov = -1;
        phase_off = 0;
        step_nco(0, 1, 32'h0100_0000, 0);
        for (int i = 0; i < 300; i++) begin
            step_nco(1, 0, 0, 0);
            if (i == 0 || i == 256) begin
                checks++;
                if (addr1 !== 8'd0) begin errors++; $display("FAIL stream_addr_wrap: got %0d expected 0", addr1); end
            end
            if (out_valid && first_ov < 0) first_ov = i;
        end
        checks++;
        if (first_ov != 2) begin errors++; $display("FAIL stream_latency: got step %0d expected 2", first_ov); end
        repeat (3) step_nco(0, 0, 0, 0);
    endtask

    task automatic test_reset_midload();
        step_nco(0, 0, 0, 1);
        ld_valid = 1;
        for (int i = 0; i < 100; i++) begin
            ld_data = tbl[i];
            @(posedge clk); #1;
        end
        rst = 1; reload = 1; fcw_we = 1; fcw = 32'h1234_5678; en = 1; ld_data = 32'hCAFE_F00D;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_in_rst: got %b expected 0", ld_ready); end
        @(posedge clk); #1;
        checks++;
        if ({csb0, web0, wmask0, addr0, din0, csb1, addr1, sin_out, cos_out, out_valid, table_ready} !== RST_VEC) begin
            errors++;
            $display("FAIL midload_reset: got %h expected %h",
                {csb0, web0, wmask0, addr0, din0, csb1, addr1, sin_out, cos_out, out_valid, table_ready}, RST_VEC);
        end
        rst = 0; reload = 0; fcw_we = 0; en = 0; ld_valid = 0;
        model_clear();
        test_load();
    endtask

    task automatic test_offset_wrap();
        phase_off = 32'h8000_0000;
        step_nco(1, 0, 0, 0);
        step_nco(1, 0, 0, 0);
        checks++;
        if (addr1 !== 8'd128) begin errors++; $display("FAIL fcw_cleared_by_rst: got %0d expected 128", addr1); end
        step_nco(0, 1, 32'hFF00_0000, 0);
        for (int i = 0; i < 300; i++) begin
            step_nco(1, 0, 0, 0);
            if (i < 2) begin
                checks++;
                if (addr1 !== 8'(128 - i)) begin errors++; $display("FAIL offset_addr: got %0d expected %0d", addr1, 128 - i); end
            end
        end
        repeat (3) step_nco(0, 0, 0, 0);
    endtask

    task automatic test_en_gaps();
        logic [4:0] pat;
        pat = 5'b11001;
        phase_off = 32'h0123_4567;
        for (int r = 0; r < 4; r++)
            for (int i = 4; i >= 0; i--) begin
                step_nco(pat[i], 0, 0, 0);
                if (!pat[i]) begin
                    checks++;
                    if (csb1 !== 1'b1) begin errors++; $display("FAIL gap_csb1: got %b expected 1", csb1); end
                end
            end
        repeat (3) step_nco(0, 0, 0, 0);
    endtask

    task automatic test_fcw_same_cycle();
        phase_off = 0;
        step_nco(1, 1, 32'h0300_0000, 0);
        for (int i = 0; i < 10; i++) step_nco(1, 0, 0, 0);
        step_nco(1, 1, 32'h0010_0000, 0);
        for (int i = 0; i < 10; i++) step_nco(1, 0, 0, 0);
        repeat (3) step_nco(0, 0, 0, 0);
    endtask

    task automatic test_reload();
        step_nco(1, 0, 0, 0);
        step_nco(1, 0, 0, 0);
        step_nco(1, 0, 0, 1);
        checks++;
        if ({ld_ready, table_ready, out_valid, csb1} !== 4'b1001) begin
            errors++; $display("FAIL reload_run: got %b expected 1001", {ld_ready, table_ready, out_valid, csb1});
        end
        repeat (4) step_nco(1, 0, 0, 0);
        ld_valid = 1;
        for (int i = 0; i < 10; i++) begin
            ld_data = tbl[i];
            @(posedge clk); #1;
        end
        reload = 1; ld_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        checks++;
        if (csb0 !== 1'b1) begin errors++; $display("FAIL reload_in_load_write: got csb0=%b expected 1", csb0); end
        reload = 0; ld_valid = 0;
        test_load();
        for (int i = 0; i < 20; i++) step_nco(1, 0, 0, 0);
        repeat (3) step_nco(0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, c;
        for (int k = 0; k < 256; k++) begin
            s = 16'(k * 613 + 12345);
            c = 16'(k * 389) ^ 16'h5A3C;
            tbl[k] = {c, s};
        end
        test_reset();
        test_load();
        test_stream();
        test_reset_midload();
        test_offset_wrap();
        test_en_gaps();
        test_fcw_same_cycle();
        test_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
